// File: rtl/snn_ff_pkg.sv
// Shared op codes and dispatcher state encoding for the spike event path.
package snn_ff_pkg;

  typedef enum logic [1:0] {
    OP_SPIKE = 2'b00,
    OP_LEAK  = 2'b01,
    OP_VIRT  = 2'b10,
    OP_RSVD  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_POP   = 2'b01,
    ST_CAPT  = 2'b10,
    ST_SWEEP = 2'b11
  } state_t;

  localparam int DROP_W = 8;

  function automatic logic is_rsvd(input op_t op);
    return op == OP_RSVD;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/event_dispatcher.sv
// Pops one scheduler event at a time and sweeps it across all N post-neurons
// as a valid/ready request stream; reserved-code events are counted and dropped.
//
//   state | meaning
//   IDLE  | waiting for enable and a non-empty scheduler FIFO
//   POP   | one-cycle active-low pop pulse to the scheduler
//   CAPT  | FIFO word now valid: latch op/address or drop reserved code
//   SWEEP | issue one request per post-neuron index 0..N-1
module event_dispatcher
  import snn_ff_pkg::*;
#(
  parameter int N = 256,
  parameter int M = 10,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              CTRL_EN,
  input  logic              SCHED_EMPTY,
  input  logic [M+1:0]      SCHED_DATA_OUT,
  output logic              CTRL_SCHED_POP_N,
  output logic              DISP_VALID,
  input  logic              DISP_READY,
  output logic [1:0]        DISP_OP,
  output logic [M-1:0]      DISP_PRE_ADDR,
  output logic [IW-1:0]     DISP_POST_IDX,
  output logic              DISP_LAST,
  output logic              DISP_BUSY,
  output logic [DROP_W-1:0] DROP_CNT
);

  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  state_t        state;
  op_t           fifo_op;
  logic [M-1:0]  fifo_addr;
  logic [IW-1:0] idx_nxt;
  logic          drop;

  assign fifo_op   = op_t'(SCHED_DATA_OUT[M+1:M]);
  assign fifo_addr = SCHED_DATA_OUT[M-1:0];
  assign idx_nxt   = DISP_POST_IDX + IW'(1);
  assign drop      = (state == ST_CAPT) && is_rsvd(fifo_op);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state            <= ST_IDLE;
      CTRL_SCHED_POP_N <= 1'b1;
      DISP_VALID       <= 1'b0;
      DISP_LAST        <= 1'b0;
      DISP_BUSY        <= 1'b0;
      DISP_OP          <= OP_SPIKE;
      DISP_PRE_ADDR    <= '0;
      DISP_POST_IDX    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (CTRL_EN && !SCHED_EMPTY) begin
            state            <= ST_POP;
            CTRL_SCHED_POP_N <= 1'b0;
            DISP_BUSY        <= 1'b1;
          end
        end

        ST_POP: begin
          state            <= ST_CAPT;
          CTRL_SCHED_POP_N <= 1'b1;
        end

        ST_CAPT: begin
          DISP_POST_IDX <= '0;
          if (drop) begin
            state     <= ST_IDLE;
            DISP_BUSY <= 1'b0;
          end else begin
            state         <= ST_SWEEP;
            DISP_OP       <= fifo_op;
            DISP_PRE_ADDR <= fifo_addr;
            DISP_VALID    <= 1'b1;
            DISP_LAST     <= (IDX_LAST == '0);
          end
        end

        ST_SWEEP: begin
          // Index only advances on a handshake and never past N-1.
          if (DISP_VALID && DISP_READY) begin
            if (DISP_LAST) begin
              state      <= ST_IDLE;
              DISP_VALID <= 1'b0;
              DISP_LAST  <= 1'b0;
              DISP_BUSY  <= 1'b0;
            end else begin
              DISP_POST_IDX <= idx_nxt;
              DISP_LAST     <= (idx_nxt == IDX_LAST);
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  sat_counter #(
    .W(DROP_W)
  ) u_drop_cnt (
    .clk  (CLK),
    .rst_n(RSTN),
    .inc  (drop),
    .count(DROP_CNT)
  );

endmodule

// File: tb/tb_event_dispatcher.sv
// Directed/randomised bench: FIFO model feeds the dispatcher, an event-level
// scoreboard predicts every request of every sweep.
module tb_event_dispatcher;

  localparam int N  = 256;
  localparam int M  = 10;
  localparam int IW = 8;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic          CTRL_EN = 1'b0;
  logic          SCHED_EMPTY = 1'b1;
  logic [M+1:0]  SCHED_DATA_OUT = '0;
  logic          DISP_READY = 1'b0;
  logic          CTRL_SCHED_POP_N;
  logic          DISP_VALID;
  logic [1:0]    DISP_OP;
  logic [M-1:0]  DISP_PRE_ADDR;
  logic [IW-1:0] DISP_POST_IDX;
  logic          DISP_LAST;
  logic          DISP_BUSY;
  logic [7:0]    DROP_CNT;

  event_dispatcher #(.N(N), .M(M)) dut (
    .CLK             (CLK),
    .RSTN            (RSTN),
    .CTRL_EN         (CTRL_EN),
    .SCHED_EMPTY     (SCHED_EMPTY),
    .SCHED_DATA_OUT  (SCHED_DATA_OUT),
    .CTRL_SCHED_POP_N(CTRL_SCHED_POP_N),
    .DISP_VALID      (DISP_VALID),
    .DISP_READY      (DISP_READY),
    .DISP_OP         (DISP_OP),
    .DISP_PRE_ADDR   (DISP_PRE_ADDR),
    .DISP_POST_IDX   (DISP_POST_IDX),
    .DISP_LAST       (DISP_LAST),
    .DISP_BUSY       (DISP_BUSY),
    .DROP_CNT        (DROP_CNT)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  logic [11:0] fq[$];
  logic [11:0] exp_ev[$];
  int exp_idx    = 0;
  int exp_drop   = 0;
  int pops       = 0;
  int valids     = 0;
  int hs_cnt     = 0;
  int ready_mode = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [11:0] w);
    fq.push_back(w);
    SCHED_EMPTY = 1'b0;
  endtask

  function automatic logic done_f();
    return (fq.size() == 0) && !DISP_BUSY && CTRL_SCHED_POP_N;
  endfunction

  // One clock: advance the FIFO and scoreboard models, then check outputs.
  task automatic step();
    logic hs, popped;
    logic [11:0] w;
    hs     = DISP_VALID && DISP_READY && RSTN;
    popped = !CTRL_SCHED_POP_N && RSTN;
    @(posedge CLK);
    #1;
    if (hs) begin
      hs_cnt++;
      exp_idx++;
      if (exp_idx == N) begin
        exp_idx = 0;
        if (exp_ev.size() > 0) exp_ev.delete(0);
      end
    end
    if (popped) begin
      pops++;
      chk("pop_pulse_width", 32'(CTRL_SCHED_POP_N), 32'd1);
      chk("pop_nonempty", 32'(fq.size() > 0), 32'd1);
      if (fq.size() > 0) begin
        w = fq.pop_front();
        SCHED_DATA_OUT = w;
        if (w[11:10] == 2'b11) begin
          if (exp_drop < 255) exp_drop++;
        end else begin
          exp_ev.push_back(w);
        end
      end
    end
    SCHED_EMPTY = (fq.size() == 0);
    if (DISP_VALID) begin
      valids++;
      chk("valid_has_event", 32'(exp_ev.size() > 0), 32'd1);
      if (exp_ev.size() > 0) begin
        chk("op", 32'(DISP_OP), 32'(exp_ev[0][11:10]));
        chk("pre_addr", 32'(DISP_PRE_ADDR), 32'(exp_ev[0][9:0]));
        chk("post_idx", 32'(DISP_POST_IDX), exp_idx);
        chk("last", 32'(DISP_LAST), 32'(exp_idx == N - 1));
        chk("busy_in_sweep", 32'(DISP_BUSY), 32'd1);
      end
    end else begin
      chk("last_without_valid", 32'(DISP_LAST), 32'd0);
    end
    if (ready_mode == 0) DISP_READY = 1'b1;
    else DISP_READY = ($urandom_range(0, 2) == 0);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k;
    k = 0;
    while (!done_f() && k < budget) begin
      step();
      k++;
    end
    chk({tag, "_timeout"}, 32'(k < budget), 32'd1);
  endtask

  task automatic run_to_idx(input int idx, input string tag);
    int k;
    k = 0;
    while (!(DISP_VALID && (32'(DISP_POST_IDX) == idx)) && k < 600) begin
      step();
      k++;
    end
    chk({tag, "_reach_idx"}, 32'(k < 600), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pop_n"}, 32'(CTRL_SCHED_POP_N), 32'd1);
    chk({tag, "_valid"}, 32'(DISP_VALID), 32'd0);
    chk({tag, "_last"}, 32'(DISP_LAST), 32'd0);
    chk({tag, "_busy"}, 32'(DISP_BUSY), 32'd0);
    chk({tag, "_op"}, 32'(DISP_OP), 32'd0);
    chk({tag, "_pre_addr"}, 32'(DISP_PRE_ADDR), 32'd0);
    chk({tag, "_post_idx"}, 32'(DISP_POST_IDX), 32'd0);
    chk({tag, "_drop_cnt"}, 32'(DROP_CNT), 32'd0);
  endtask

  initial begin
    int lat, k, gaps;
    logic seen;

    // Reset values
    RSTN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk_reset_vals("reset");
    RSTN = 1'b1;
    step();
    step();
    chk("idle_empty_no_busy", 32'(DISP_BUSY), 32'd0);

    // Single spike event, always ready, latency from EMPTY falling
    CTRL_EN = 1'b1;
    pops = 0; hs_cnt = 0;
    push({2'b00, 10'h2A5});
    lat = 0;
    while (!DISP_VALID && lat < 10) begin
      step();
      lat++;
    end
    chk("t1_latency", lat, 32'd3);
    wait_done(400, "t1");
    chk("t1_pops", pops, 32'd1);
    chk("t1_handshakes", hs_cnt, 32'd256);
    chk("t1_scoreboard_empty", exp_ev.size(), 32'd0);

    // Leak event with ready asserted roughly one cycle in three
    ready_mode = 1; DISP_READY = 1'b0;
    pops = 0; hs_cnt = 0; valids = 0;
    push({2'b01, 10'h000});
    wait_done(3000, "t2");
    chk("t2_handshakes", hs_cnt, 32'd256);
    chk("t2_stalls_seen", 32'(valids > hs_cnt), 32'd1);
    chk("t2_scoreboard_empty", exp_ev.size(), 32'd0);
    ready_mode = 0;

    // Four back-to-back random events
    pops = 0; hs_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] op;
      logic [9:0] ad;
      op = 2'($urandom_range(0, 2));
      ad = 10'($urandom_range(0, 1023));
      push({op, ad});
    end
    k = 0; gaps = 0; seen = 1'b0;
    while (!done_f() && k < 2000) begin
      step();
      k++;
      if (DISP_BUSY) seen = 1'b1;
      else if (seen && !done_f()) gaps++;
    end
    chk("t3_timeout", 32'(k < 2000), 32'd1);
    chk("t3_pops", pops, 32'd4);
    chk("t3_idle_gaps", gaps, 32'd3);
    chk("t3_handshakes", hs_cnt, 32'd1024);
    chk("t3_scoreboard_empty", exp_ev.size(), 32'd0);

    // 300 reserved-code events: counter saturates, nothing dispatched
    pops = 0; valids = 0;
    for (int i = 0; i < 300; i++) push({2'b11, 10'($urandom_range(0, 1023))});
    wait_done(1600, "t4");
    chk("t4_pops", pops, 32'd300);
    chk("t4_valid_never", valids, 32'd0);
    chk("t4_drop_model", 32'(DROP_CNT), exp_drop);
    chk("t4_drop_sat", 32'(DROP_CNT), 32'd255);

    // Enable dropped mid-sweep with events still queued
    pops = 0; hs_cnt = 0;
    for (int i = 0; i < 3; i++) push({2'b10, 10'($urandom_range(0, 1023))});
    run_to_idx(100, "t5");
    CTRL_EN = 1'b0;
    k = 0;
    while (DISP_BUSY && k < 400) begin
      step();
      k++;
    end
    chk("t5_sweep_end_timeout", 32'(k < 400), 32'd1);
    repeat (20) step();
    chk("t5_pops_while_disabled", pops, 32'd1);
    chk("t5_handshakes", hs_cnt, 32'd256);
    chk("t5_fifo_left", fq.size(), 32'd2);
    chk("t5_scoreboard_empty", exp_ev.size(), 32'd0);
    CTRL_EN = 1'b1;
    wait_done(1200, "t5b");
    chk("t5_pops_total", pops, 32'd3);
    chk("t5_handshakes_total", hs_cnt, 32'd768);

    // Reset mid-sweep
    hs_cnt = 0;
    push({2'b00, 10'($urandom_range(0, 1023))});
    push({2'b01, 10'($urandom_range(0, 1023))});
    run_to_idx(50, "t6");
    RSTN = 1'b0;
    #1;
    chk_reset_vals("t6_async");
    exp_ev.delete();
    exp_idx = 0;
    exp_drop = 0;
    step();
    step();
    RSTN = 1'b1;
    #1;
    chk("t6_release_no_pop", 32'(CTRL_SCHED_POP_N), 32'd1);
    hs_cnt = 0;
    wait_done(600, "t6");
    chk("t6_handshakes", hs_cnt, 32'd256);
    chk("t6_scoreboard_empty", exp_ev.size(), 32'd0);
    chk("t6_drop_after_reset", 32'(DROP_CNT), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
